me_control: RTL and testbench
=============================

ME_CONTROL -- requirements
Module: me_control

Interface
REQ-001 The block SHALL have ports: clock  input  1  single system clock, all state on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle request to begin a block search; sampled only in IDLE.
REQ-004 Accumulate  input  8  running SAD from the pe instance, registered inside pe, saturating at 8'hFF.
REQ-005 AddressR  output  4  reference-block memory address, 16 pixels, row-major.
REQ-006 AddressS1, AddressS2  output  5 each  left/right search-half memory addresses, 8 rows x 4 columns each.
REQ-007 s1s2mux  output  1  to pe; 1 selects s1 (window columns 0-3), 0 selects s2 (columns 4-7).
REQ-008 newDist  output  1  to pe; 1 on the first pixel of each candidate.
REQ-009 busy  output  1  high in COMPUTE and DRAIN.
REQ-010 done  output  1  one-cycle pulse when results are final.
REQ-011 BestDist  output  8  minimum SAD found.
REQ-012 BestX, BestY  output  3 each  winning displacement dx, dy, range 0..4.

Function
REQ-013 Geometry SHALL be fixed: 4x4 reference block, 8x8 search window, 25 candidates (dy outer 0..4, dx inner 0..4), candidate index k = 5*dy + dx.
REQ-014 Per candidate, pixel p = 4*i + j (i row, j col, 0..3) SHALL be issued one per cycle for 16 cycles.
REQ-015 For pixel p: AddressR = p; r = dy+i, c = dx+j; AddressS1 = AddressS2 = {r[2:0], c[1:0]}; s1s2mux = ~c[2]; newDist = (p == 0).
REQ-016 All outputs SHALL be registered; memories are combinational-read, so data reaches pe in the same cycle as its address.
REQ-017 FSM states SHALL be IDLE, COMPUTE, DRAIN, DONE.
REQ-018 IDLE -> COMPUTE on the edge sampling start=1 (edge 0); pixel 0 of candidate 0 is presented in the cycle after edge 0.
REQ-019 COMPUTE SHALL last 400 cycles; edge 400 -> DRAIN; edge 401 -> DONE with done=1; the following edge -> IDLE with done=0.
REQ-020 A compare-valid flag SHALL be set on the edge after pixel 15 of any candidate is presented (edge 16k+16); the comparator SHALL sample Accumulate on the next edge (16k+17).
REQ-021 Candidate 0 SHALL load unconditionally; later candidates SHALL replace the best only if Accumulate < BestDist (strict, so ties keep the earliest k).
REQ-022 On replacement, BestDist, BestX and BestY SHALL update on the same edge.
REQ-023 Results SHALL hold from DONE until the edge that samples the next start; that edge SHALL clear them to reset values.
REQ-024 start SHALL be ignored in COMPUTE, DRAIN and DONE.
REQ-025 In IDLE and DONE, addresses SHALL be 0 and newDist = 0, s1s2mux = 0.
REQ-026 An 8'hFF Accumulate SHALL be treated as an ordinary value; saturation is not flagged.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, with all address outputs, s1s2mux, newDist, busy and done = 0.
REQ-028 reset_n low SHALL also set BestDist = 8'hFF, BestX = BestY = 0 and clear the counters and compare-valid flag.
REQ-029 Reset asserted mid-search SHALL abandon the search with no done pulse; after release, the block SHALL wait for a new start.

Verification
REQ-030 All-zero memories, start -> busy high edges 0..400, done pulse after edge 401, BestDist=00, BestX=0, BestY=0.
REQ-031 Window region at (dx=3, dy=2) equals the reference block, all other SADs nonzero -> BestDist=00, BestX=3, BestY=2.
REQ-032 SAD=8'h10 at (1,0) and at (4,4), all others >8'h10 -> BestX=1, BestY=0 (tie keeps earliest).
REQ-033 Every SAD saturates at 8'hFF -> BestDist=FF, BestX=0, BestY=0.
REQ-034 Address trace: cycle after edge 0 -> AddressR=0, AddressS1=0, s1s2mux=1, newDist=1; candidate dx=1, dy=0, pixel i=0, j=3 (c=4) -> AddressR=3, AddressS2=5'b00000, s1s2mux=0, newDist=0.
REQ-035 reset_n low at edge 200 -> all outputs immediately at reset values, no done pulse; start pulsed at edge 201 while busy=1 -> ignored.

Source files
------------

// File: rtl/me_control.sv
// Control block for a 4x4 full-search motion estimator. It walks 25 candidates
// over an 8x8 search window, drives the memory addresses and keeps the best SAD.
module me_control (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] Accumulate,
  output logic [3:0] AddressR,
  output logic [4:0] AddressS1,
  output logic [4:0] AddressS2,
  output logic       s1s2mux,
  output logic       newDist,
  output logic       busy,
  output logic       done,
  output logic [7:0] BestDist,
  output logic [2:0] BestX,
  output logic [2:0] BestY
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

  state_t      state_reg;
  logic [8:0]  cnt_reg;
  logic [3:0]  pix_reg;
  logic [2:0]  dx_reg;
  logic [2:0]  dy_reg;
  logic        cmp_valid_reg;
  logic [2:0]  cmp_x_reg;
  logic [2:0]  cmp_y_reg;

  logic [3:0]  pix_next;
  logic [2:0]  dx_next;
  logic [2:0]  dy_next;
  logic [2:0]  row_next;
  logic [2:0]  col_next;

  // Next pixel to present; leaving IDLE always restarts at pixel 0 of candidate 0.
  always_comb begin
    pix_next = pix_reg + 4'd1;
    dx_next  = dx_reg;
    dy_next  = dy_reg;
    if (pix_reg == 4'd15) begin
      if (dx_reg == 3'd4) begin
        dx_next = 3'd0;
        dy_next = dy_reg + 3'd1;
      end else begin
        dx_next = dx_reg + 3'd1;
      end
    end
    if (state_reg == IDLE) begin
      pix_next = 4'd0;
      dx_next  = 3'd0;
      dy_next  = 3'd0;
    end
    row_next = dy_next + {1'b0, pix_next[3:2]};
    col_next = dx_next + {1'b0, pix_next[1:0]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 9'd0;
      pix_reg       <= 4'd0;
      dx_reg        <= 3'd0;
      dy_reg        <= 3'd0;
      cmp_valid_reg <= 1'b0;
      cmp_x_reg     <= 3'd0;
      cmp_y_reg     <= 3'd0;
      AddressR      <= 4'd0;
      AddressS1     <= 5'd0;
      AddressS2     <= 5'd0;
      s1s2mux       <= 1'b0;
      newDist       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      BestDist      <= 8'hFF;
      BestX         <= 3'd0;
      BestY         <= 3'd0;
    end else begin
      // Flag goes up the edge after pixel 15 is presented; pe needs one more edge.
      cmp_valid_reg <= (state_reg == COMPUTE) && (pix_reg == 4'd15);
      cmp_x_reg     <= dx_reg;
      cmp_y_reg     <= dy_reg;

      if (cmp_valid_reg &&
          (((cmp_x_reg == 3'd0) && (cmp_y_reg == 3'd0)) || (Accumulate < BestDist))) begin
        BestDist <= Accumulate;
        BestX    <= cmp_x_reg;
        BestY    <= cmp_y_reg;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= COMPUTE;
            busy      <= 1'b1;
            cnt_reg   <= 9'd1;
            pix_reg   <= pix_next;
            dx_reg    <= dx_next;
            dy_reg    <= dy_next;
            AddressR  <= pix_next;
            AddressS1 <= {row_next, col_next[1:0]};
            AddressS2 <= {row_next, col_next[1:0]};
            s1s2mux   <= ~col_next[2];
            newDist   <= (pix_next == 4'd0);
            BestDist  <= 8'hFF;
            BestX     <= 3'd0;
            BestY     <= 3'd0;
          end
        end
        COMPUTE: begin
          if (cnt_reg == 9'd400) begin
            state_reg <= DRAIN;
            AddressR  <= 4'd0;
            AddressS1 <= 5'd0;
            AddressS2 <= 5'd0;
            s1s2mux   <= 1'b0;
            newDist   <= 1'b0;
          end else begin
            cnt_reg   <= cnt_reg + 9'd1;
            pix_reg   <= pix_next;
            dx_reg    <= dx_next;
            dy_reg    <= dy_next;
            AddressR  <= pix_next;
            AddressS1 <= {row_next, col_next[1:0]};
            AddressS2 <= {row_next, col_next[1:0]};
            s1s2mux   <= ~col_next[2];
            newDist   <= (pix_next == 4'd0);
          end
        end
        DRAIN: begin
          state_reg <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_control.sv
// Bench for me_control: models the pe and the three memories, then checks
// search timing, address trace, reset behaviour and best-match results.
module tb_me_control;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] Accumulate;
  logic [3:0] AddressR;
  logic [4:0] AddressS1, AddressS2;
  logic       s1s2mux, newDist, busy, done;
  logic [7:0] BestDist;
  logic [2:0] BestX, BestY;

  me_control dut (
    .clock(clock), .reset_n(reset_n), .start(start), .Accumulate(Accumulate),
    .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .s1s2mux(s1s2mux), .newDist(newDist), .busy(busy), .done(done),
    .BestDist(BestDist), .BestX(BestX), .BestY(BestY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Memories: reference block and the two halves of the search window.
  logic [7:0] refm [16];
  logic [7:0] s1m  [32];
  logic [7:0] s2m  [32];
  int         win  [8][8];

  // pe model: absolute difference accumulated with saturation.
  logic [7:0] rd, sd, diff;
  logic [8:0] sum;
  assign rd   = refm[AddressR];
  assign sd   = s1s2mux ? s1m[AddressS1] : s2m[AddressS2];
  assign diff = (rd > sd) ? rd - sd : sd - rd;
  assign sum  = {1'b0, Accumulate} + {1'b0, diff};
  always_ff @(posedge clock) begin
    if (newDist) Accumulate <= diff;
    else         Accumulate <= sum[8] ? 8'hFF : sum[7:0];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // mode 0 zeros, 1 exact match at (3,2), 2 tie at (1,0)/(4,4), 3 all saturate,
  // 4 random full range, 5 random small values.
  task automatic fill(input int mode);
    for (int p = 0; p < 16; p++) begin
      case (mode)
        1:       refm[p] = 8'(3 * p + 1);
        4:       refm[p] = 8'($urandom_range(0, 255));
        5:       refm[p] = 8'($urandom_range(0, 15));
        default: refm[p] = 8'd0;
      endcase
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        case (mode)
          0: win[r][c] = 0;
          1: win[r][c] = (r >= 2 && r < 6 && c >= 3 && c < 7) ? int'(refm[4*(r-2)+(c-3)]) : 200;
          2: win[r][c] = ((r < 4 && c >= 1 && c < 5) || (r >= 4 && c >= 4)) ? 1 : 255;
          3: win[r][c] = 255;
          4: win[r][c] = $urandom_range(0, 255);
          default: win[r][c] = $urandom_range(0, 15);
        endcase
      end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (c < 4) s1m[r*4+c]     = 8'(win[r][c]);
        else       s2m[r*4+c-4]   = 8'(win[r][c]);
  endtask

  // Reference result: direct SAD over every displacement, first minimum wins.
  task automatic model(output logic [7:0] bd, output logic [2:0] bx, output logic [2:0] by);
    int best;
    best = 1000; bx = 0; by = 0;
    for (int dy = 0; dy < 5; dy++)
      for (int dx = 0; dx < 5; dx++) begin
        int sad;
        sad = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            int a, b;
            a = int'(refm[4*i+j]);
            b = win[dy+i][dx+j];
            sad += (a > b) ? a - b : b - a;
          end
        if (sad > 255) sad = 255;
        if (sad < best) begin
          best = sad; bx = 3'(dx); by = 3'(dy);
        end
      end
    bd = 8'(best);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"}, {AddressR, AddressS1, AddressS2}, 0);
    chk({tag, "_mux_nd"}, {s1s2mux, newDist}, 0);
    chk({tag, "_busy_done"}, {busy, done}, 0);
    chk({tag, "_bestdist"}, BestDist, 8'hFF);
    chk({tag, "_bestxy"}, {BestX, BestY}, 0);
  endtask

  task automatic run_search(input logic [7:0] ed, input logic [2:0] ex, input logic [2:0] ey,
                            input int restart_at, input string nm);
    int done_edge;
    done_edge = -1;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    chk({nm, "_e0_busy"}, busy, 1);
    chk({nm, "_e0_cleared"}, {BestDist, BestX, BestY}, {8'hFF, 6'd0});
    chk({nm, "_e0_trace"}, {AddressR, AddressS1, s1s2mux, newDist}, {4'd0, 5'd0, 1'b1, 1'b1});
    for (int n = 1; n <= 420 && done_edge < 0; n++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (n == restart_at) start = 1'b1;
      if (n == 16)  chk({nm, "_e16_newdist"}, {AddressR, newDist}, {4'd0, 1'b1});
      if (n == 19)  chk({nm, "_e19_trace"}, {AddressR, AddressS2, s1s2mux, newDist},
                        {4'd3, 5'd0, 1'b0, 1'b0});
      if (n == 400) chk({nm, "_e400_busy"}, busy, 1);
      if (done) done_edge = n;
    end
    start = 1'b0;
    chk({nm, "_done_edge"}, done_edge, 401);
    chk({nm, "_busy_at_done"}, busy, 0);
    chk({nm, "_bestdist"}, BestDist, ed);
    chk({nm, "_bestx"}, BestX, ex);
    chk({nm, "_besty"}, BestY, ey);
    @(posedge clock); #1;
    chk({nm, "_done_pulse_end"}, done, 0);
    chk({nm, "_hold"}, {BestDist, BestX, BestY}, {ed, ex, ey});
    $display("search %s: BestDist=%02h BestX=%0d BestY=%0d done_edge=%0d", nm, BestDist, BestX, BestY, done_edge);
  endtask

  typedef struct {
    int         mode;
    logic [7:0] ed;
    logic [2:0] ex;
    logic [2:0] ey;
    int         restart_at;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [7:0] md;
    logic [2:0] mx, my;
    int seen_done, seen_busy;

    vecs[0] = '{0, 8'h00, 3'd0, 3'd0, -1};
    vecs[1] = '{1, 8'h00, 3'd3, 3'd2, 201};
    vecs[2] = '{2, 8'h10, 3'd1, 3'd0, -1};
    vecs[3] = '{3, 8'hFF, 3'd0, 3'd0, -1};

    reset_n = 1'b0; start = 1'b0;
    fill(0);
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outs("reset");
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(posedge clock);

    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].mode);
      run_search(vecs[v].ed, vecs[v].ex, vecs[v].ey, vecs[v].restart_at, $sformatf("vec%0d", v));
    end

    // Reset in the middle of a search: immediate reset values, no done later.
    fill(4);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (199) @(posedge clock);
    #3; reset_n = 1'b0;
    #1;
    chk_reset_outs("midreset");
    @(negedge clock); reset_n = 1'b1;
    seen_done = 0; seen_busy = 0;
    for (int n = 0; n < 450; n++) begin
      @(posedge clock); #1;
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    chk("midreset_no_done", seen_done, 0);
    chk("midreset_stays_idle", seen_busy, 0);
    $display("midreset: done_pulses=%0d busy_cycles=%0d", seen_done, seen_busy);

    for (int t = 0; t < 6; t++) begin
      fill((t % 2 == 0) ? 4 : 5);
      model(md, mx, my);
      run_search(md, mx, my, -1, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
